// File: rtl/hsiao2_64_pkg.sv
// Shared Hsiao (72,64) SEC-DED definitions for the encoder and hsiao2_64_dec.
// Each H column value is read MSB-first: bit 7 of H_COL[j] drives check bit 0
// (code bit 64) and bit 0 drives check bit 7 (code bit 71).
package hsiao2_64_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CHK_W  = 8;
  localparam int unsigned CODE_W = 72;

  // 56 weight-3 columns in ascending order, then the first 8 weight-5 values
  // in ascending order.
  localparam logic [CHK_W-1:0] H_COL [0:DATA_W-1] = '{
    8'h07, 8'h0B, 8'h0D, 8'h0E, 8'h13, 8'h15, 8'h16, 8'h19,
    8'h1A, 8'h1C, 8'h23, 8'h25, 8'h26, 8'h29, 8'h2A, 8'h2C,
    8'h31, 8'h32, 8'h34, 8'h38, 8'h43, 8'h45, 8'h46, 8'h49,
    8'h4A, 8'h4C, 8'h51, 8'h52, 8'h54, 8'h58, 8'h61, 8'h62,
    8'h64, 8'h68, 8'h70, 8'h83, 8'h85, 8'h86, 8'h89, 8'h8A,
    8'h8C, 8'h91, 8'h92, 8'h94, 8'h98, 8'hA1, 8'hA2, 8'hA4,
    8'hA8, 8'hB0, 8'hC1, 8'hC2, 8'hC4, 8'hC8, 8'hD0, 8'hE0,
    8'h1F, 8'h2F, 8'h37, 8'h3B, 8'h3D, 8'h3E, 8'h4F, 8'h57
  };

  // Flat reference of the check byte for a whole data word.
  function automatic logic [CHK_W-1:0] hsiao2_chk(input logic [0:DATA_W-1] data);
    logic [CHK_W-1:0] chk;
    chk = '0;
    for (int j = 0; j < DATA_W; j++) begin
      if (data[j]) chk = chk ^ H_COL[6'(j)];
    end
    return chk;
  endfunction

endpackage

// File: rtl/hsiao2_64_par_half.sv
// Partial check parity over a 32-bit half of the data word, using the H_COL
// entries starting at OFFSET.
module hsiao2_64_par_half
  import hsiao2_64_pkg::*;
#(
  parameter int unsigned OFFSET = 0
) (
  input  logic [0:31]      data,
  output logic [CHK_W-1:0] par
);

  // XOR together the H columns of every set data bit in this half.
  always_comb begin
    par = '0;
    for (int i = 0; i < 32; i++) begin
      if (data[i]) par = par ^ H_COL[6'(OFFSET + i)];
    end
  end

endmodule

// File: rtl/hsiao2_64_enc.sv
// Two-stage pipelined Hsiao (72,64) encoder with valid/ready flow control and
// a saturating count of delivered codewords.
// Optional build macro HSIAO2_ENC_ERR_INJ_EN adds i_inj_mask/i_inj_en, which
// XOR a mask into the codeword as it loads into stage 2.
module hsiao2_64_enc
  import hsiao2_64_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [0:63]       i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [0:71]       o_code,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_cnt
`ifdef HSIAO2_ENC_ERR_INJ_EN
  ,
  input  logic [0:71]       i_inj_mask,
  input  logic              i_inj_en
`endif
);

  logic [0:63]      s1_data_q, s1_data_d;
  logic [CHK_W-1:0] s1_pa_q, s1_pa_d, s1_pb_q, s1_pb_d;
  logic             s1_valid_q, s1_valid_d;
  logic [0:71]      s2_code_q, s2_code_d;
  logic             s2_valid_q, s2_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHK_W-1:0] par_a, par_b;
  logic             adv1, adv2, xfer;

  hsiao2_64_par_half #(.OFFSET(0)) u_par_a (
    .data (i_data[0:31]),
    .par  (par_a)
  );

  hsiao2_64_par_half #(.OFFSET(32)) u_par_b (
    .data (i_data[32:63]),
    .par  (par_b)
  );

  // Stage advance terms; a bubble in s2 is refilled even when downstream stalls.
  always_comb begin
    adv2 = enable & (~s2_valid_q | i_ready);
    adv1 = enable & (~s1_valid_q | adv2);
    xfer = s2_valid_q & i_ready & enable;
  end

  // Next-state for both stages and the delivered-word counter.
  always_comb begin
    s1_data_d  = s1_data_q;
    s1_pa_d    = s1_pa_q;
    s1_pb_d    = s1_pb_q;
    s1_valid_d = s1_valid_q;
    s2_code_d  = s2_code_q;
    s2_valid_d = s2_valid_q;
    cnt_d      = cnt_q;
    if (adv1) begin
      s1_data_d  = i_data;
      s1_pa_d    = par_a;
      s1_pb_d    = par_b;
      s1_valid_d = i_valid;
    end
    if (adv2) begin
      s2_code_d  = {s1_data_q, s1_pa_q ^ s1_pb_q};
      s2_valid_d = s1_valid_q;
`ifdef HSIAO2_ENC_ERR_INJ_EN
      if (i_inj_en) s2_code_d = s2_code_d ^ i_inj_mask;
`endif
    end
    if (xfer && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Pipeline and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_data_q  <= '0;
      s1_pa_q    <= '0;
      s1_pb_q    <= '0;
      s1_valid_q <= 1'b0;
      s2_code_q  <= '0;
      s2_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_pa_q    <= s1_pa_d;
      s1_pb_q    <= s1_pb_d;
      s1_valid_q <= s1_valid_d;
      s2_code_q  <= s2_code_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_ready = adv1;
  assign o_code  = s2_code_q;
  assign o_valid = s2_valid_q;
  assign o_cnt   = cnt_q;

endmodule

// File: tb/tb_hsiao2_64_enc.sv
// Bench for hsiao2_64_enc: directed phases with random data, checked against a
// word-level model (queue of in-flight words with their age in enabled cycles).
module tb_hsiao2_64_enc;
  import hsiao2_64_pkg::hsiao2_chk;

  localparam int unsigned CW = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          reset_n, enable, i_valid, i_ready, o_ready, o_valid;
  logic [0:63]   i_data;
  logic [0:71]   o_code;
  logic [CW-1:0] o_cnt;
`ifdef HSIAO2_ENC_ERR_INJ_EN
  logic [0:71]   i_inj_mask;
  logic          i_inj_en;
`endif

  always #5 clk = ~clk;

  hsiao2_64_enc #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_code     (o_code),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_cnt      (o_cnt)
`ifdef HSIAO2_ENC_ERR_INJ_EN
    ,
    .i_inj_mask (i_inj_mask),
    .i_inj_en   (i_inj_en)
`endif
  );

  typedef struct {
    logic [63:0] data;
    int          age;
  } ent_t;

  ent_t        q[$];
  int          cnt_m;
  logic [7:0]  hcol [64];
  int          n_tests, n_fail;
  logic [71:0] inj_x;
  logic        acc_m, xfer_m, armed;
  logic [71:0] frz_code;

  // Data bit j (spec numbering) is packed bit 63-j.
  function automatic logic [71:0] enc(input logic [63:0] d);
    logic [7:0] c;
    c = '0;
    for (int j = 0; j < 64; j++) begin
      if (d[63-j]) c = c ^ hcol[j];
    end
    return {d, c};
  endfunction

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: check o_ready, advance the model at the edge, then check outputs.
  task automatic tick();
    logic        ev, er, hold;
    logic [71:0] pcode;
    #1;
    ev = (q.size() > 0) && (q[0].age >= 1);
    er = enable && ((q.size() < 2) || i_ready);
    if (armed) check("o_ready", o_ready, er);
    acc_m  = i_valid && er;
    xfer_m = ev && i_ready && enable;
    pcode  = o_code;
    hold   = armed && o_valid && !(i_ready && enable);
    @(posedge clk);
    if (!reset_n) begin
      q.delete();
      cnt_m = 0;
      armed = 1'b1;
    end else if (enable) begin
      ent_t e;
      if (xfer_m) begin
        void'(q.pop_front());
        if (cnt_m < CNT_MAX) cnt_m++;
      end
      foreach (q[k]) q[k].age++;
      if (acc_m) begin
        e.data = i_data;
        e.age  = 0;
        q.push_back(e);
      end
    end
    #1;
    if (!armed) return;
    ev = (q.size() > 0) && (q[0].age >= 1);
    check("o_valid", o_valid, ev);
    check("o_cnt", o_cnt, cnt_m);
    if (!reset_n) check("o_code_rst", o_code, 72'h0);
    else if (ev) check("o_code", o_code, enc(q[0].data) ^ inj_x);
    if (reset_n && hold) check("o_code_hold", o_code, pcode);
  endtask

  // Push n random words with random valid gaps; optionally toggle i_ready 1,0,0,1.
  task automatic run_stream(input int n, input bit toggle);
    int          sent, cyc;
    logic [63:0] w;
    sent = 0;
    cyc  = 0;
    w    = {$urandom, $urandom};
    while ((sent < n || q.size() > 0) && cyc < 400) begin
      i_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      i_valid = (sent < n) && ($urandom_range(0, 3) != 0);
      i_data  = w;
      tick();
      if (acc_m) begin
        sent++;
        w = {$urandom, $urandom};
      end
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    check("stream_bound", 72'(cyc < 400), 72'h1);
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (q.size() > 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("drain_bound", 72'(q.size()), 72'h0);
  endtask

  initial begin
    int idx, n5;
    logic [63:0] rw;
    idx = 0;
    n5  = 0;
    for (int v = 0; v < 256; v++) begin
      if ($countones(v) == 3) begin
        hcol[idx] = 8'(v);
        idx++;
      end
    end
    for (int v = 0; v < 256; v++) begin
      if ($countones(v) == 5 && n5 < 8) begin
        hcol[idx] = 8'(v);
        idx++;
        n5++;
      end
    end
    n_tests = 0;
    n_fail  = 0;
    cnt_m   = 0;
    armed   = 1'b0;
    inj_x   = '0;
    reset_n = 1'b0;
    enable  = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
`ifdef HSIAO2_ENC_ERR_INJ_EN
    i_inj_mask = '0;
    i_inj_en   = 1'b0;
`endif
    tick();
    tick();
    reset_n = 1'b1;

    // All-zero word: visible two cycles after presentation, count reaches 1.
    i_valid = 1'b1;
    i_data  = '0;
    tick();
    check("zero_not_early", o_valid, 1'b0);
    i_valid = 1'b0;
    tick();
    check("zero_code", o_code, 72'h0);
    tick();
    check("cnt_one", o_cnt, 1);

    // Single data bit 63.
    i_valid = 1'b1;
    i_data  = 64'h1;
    tick();
    i_valid = 1'b0;
    tick();
    check("bit63_code", o_code, {64'h1, 8'h57});
    check("pkg_chk_bit63", hsiao2_chk(64'h1), hcol[63]);
    rw = {$urandom, $urandom};
    check("pkg_chk_rand", hsiao2_chk(rw), enc(rw) & 72'hFF);
    tick();

    // Random stream under i_ready toggling.
    run_stream(8, 1'b1);
    check("cnt_after_stream", o_cnt, 10);

    // Freeze with two words in flight.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = {$urandom, $urandom};
    tick();
    i_data  = {$urandom, $urandom};
    tick();
    frz_code = o_code;
    enable   = 1'b0;
    i_data   = {$urandom, $urandom};
    for (int k = 0; k < 3; k++) tick();
    check("freeze_code", o_code, frz_code);
    check("freeze_cnt", o_cnt, 10);
    enable  = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    drain();
    check("cnt_after_freeze", o_cnt, 12);

    // Reset with both stages full.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = {$urandom, $urandom};
    tick();
    i_data  = {$urandom, $urandom};
    tick();
    i_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_cnt", o_cnt, 0);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = {$urandom, $urandom};
    tick();
    i_valid = 1'b0;
    tick();
    check("post_rst_valid", o_valid, 1'b1);
    tick();

    // Saturation: 21 transfers total on a 4-bit counter.
    run_stream(20, 1'b0);
    check("cnt_sat", o_cnt, CNT_MAX);

`ifdef HSIAO2_ENC_ERR_INJ_EN
    i_inj_en   = 1'b1;
    i_inj_mask = 72'h1000;
    inj_x      = 72'h1000;
    run_stream(2, 1'b1);
    i_inj_mask = 72'h50000;
    inj_x      = 72'h50000;
    run_stream(2, 1'b1);
    i_inj_en   = 1'b0;
    i_inj_mask = '0;
    inj_x      = '0;
    run_stream(2, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
